// File: rtl/imem_boot_ctrl_if.sv
// Loader-to-boot-controller word stream: valid/ready handshake with a last-word marker.
interface imem_boot_ctrl_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: loads a program image from a loader, then serves core fetches.
// Optional image checksum check is enabled by defining IMEM_BOOT_CSUM_EN.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  imem_boot_ctrl_if.slave   ld,
  input  logic [31:0]       exp_csum,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              cpu_run,
  output logic              mem_we,
  output logic [AW-1:0]     mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [AW-1:0]     mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic [AW:0]       word_count,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          done_q, done_d;
  logic          ready;
  logic          hs;
  logic          csum_ok;

`ifdef IMEM_BOOT_CSUM_EN
  logic [31:0]   csum_q, csum_d;

  assign csum_ok = (csum_q + ld.ld_data) == exp_csum;

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`else
  logic unused_csum;

  assign csum_ok     = 1'b1;
  assign unused_csum = ^exp_csum;
`endif

  logic unused_pc;
  assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

  // count_q[AW] set means DEPTH words already taken: no room left
  assign ready = (state_q == LOAD) && !count_q[AW];
  assign hs    = ready && ld.ld_valid && !load_start && !reset;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
    csum_d  = csum_q;
`endif
    if (load_start) begin
      state_d = LOAD;
      count_d = '0;
`ifdef IMEM_BOOT_CSUM_EN
      csum_d  = '0;
`endif
    end else if (hs) begin
      count_d = count_q + 1'b1;
`ifdef IMEM_BOOT_CSUM_EN
      csum_d  = csum_q + ld.ld_data;
`endif
      if (ld.ld_last) begin
        if (csum_ok) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ERR;
        end
      end else if (count_q[AW-1:0] == '1) begin
        state_d = ERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign ld.ld_ready = ready;
  assign mem_we      = hs;
  assign mem_waddr   = count_q[AW-1:0];
  assign mem_wdata   = ld.ld_data;

  assign cpu_run    = (state_q == RUN);
  assign load_err   = (state_q == ERR);
  assign load_done  = done_q;
  assign word_count = count_q;
  assign mem_raddr  = cpu_run ? pc[AW+1:2] : '0;
  assign instr      = cpu_run ? mem_rdata  : '0;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl against a behavioural model of the boot/load rules.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [31:0]   exp_csum;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          cpu_run, mem_we, load_done, load_err;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [AW:0]   word_count;

  imem_boot_ctrl_if lif();

  imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld(lif.slave),
    .exp_csum(exp_csum), .pc(pc), .instr(instr), .cpu_run(cpu_run),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .word_count(word_count),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem [DEPTH] = '{default: '0};
  always @(posedge clk) if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_raddr];

  // Behavioural model
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  bit          m_loading, m_running, m_err, m_done;
  int          m_count;
  logic [31:0] m_sum;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model past the edge.
  task automatic step(input logic rst, input logic ls, input logic v, input logic [31:0] d,
                      input logic last, input logic [31:0] p);
    bit rdy, hs, ok;
    int widx;
    reset = rst; load_start = ls; lif.ld_valid = v; lif.ld_data = d; lif.ld_last = last; pc = p;
    #2;
    rdy = m_loading && (m_count < DEPTH);
    hs  = rdy && v && !ls && !rst;
    check_eq("ld_ready", lif.ld_ready, rdy);
    check_eq("mem_we", mem_we, hs);
    if (hs) begin
      check_eq("mem_waddr", mem_waddr, m_count);
      check_eq("mem_wdata", mem_wdata, d);
    end
    check_eq("cpu_run", cpu_run, m_running);
    check_eq("load_done", load_done, m_done);
    check_eq("load_err", load_err, m_err);
    check_eq("word_count", word_count, m_count);
    widx = (p >> 2) % DEPTH;
    check_eq("mem_raddr", mem_raddr, m_running ? widx : 0);
    check_eq("instr", instr, m_running ? ref_mem[widx] : 32'h0);
`ifdef IMEM_BOOT_CSUM_EN
    ok = (m_sum + d) == exp_csum;
`else
    ok = 1'b1;
`endif
    if (rst) begin
      m_loading = 0; m_running = 0; m_err = 0; m_done = 0; m_count = 0; m_sum = '0;
    end else if (ls) begin
      m_loading = 1; m_running = 0; m_err = 0; m_done = 0; m_count = 0; m_sum = '0;
    end else begin
      m_done = 0;
      if (hs) begin
        ref_mem[m_count] = d;
        m_count++;
        m_sum += d;
        if (last) begin
          m_loading = 0;
          if (ok) begin m_running = 1; m_done = 1; end
          else m_err = 1;
        end else if (m_count == DEPTH) begin
          m_loading = 0; m_err = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom % 2, $urandom, $urandom % 2, $urandom);
  endtask

  logic [31:0] image [6] = '{32'h00500113, 32'h00C00193, 32'hFF718393,
                             32'h0023E233, 32'h0041F2B3, 32'h004282B3};

  initial begin
    logic [31:0] s;
    int n;
    reset = 1; load_start = 0; lif.ld_valid = 0; lif.ld_data = '0; lif.ld_last = 0;
    pc = '0; exp_csum = '0;
    @(posedge clk); #1;
    m_loading = 0; m_running = 0; m_err = 0; m_done = 0; m_count = 0; m_sum = '0;

    // Reset held two cycles, then valid words in IDLE must not write
    step(1, 0, 1, 32'hDEADBEEF, 0, 0);
    step(1, 0, 1, 32'hDEADBEEF, 0, 0);
    step(0, 0, 1, 32'h12345678, 0, 0);
    step(0, 0, 1, 32'h12345678, 1, 4);

    // Directed six-word image
    s = '0;
    foreach (image[i]) s += image[i];
    exp_csum = s;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, image[i], i == 5, $urandom);
    check_eq("count_after_image", word_count, 6);
    check_eq("done_after_image", load_done, 1);
    step(0, 0, 0, 0, 0, 32'h0C);
    pc = 32'h0C; #1; check_eq("instr_pc0C", instr, 32'h0023E233);
    pc = 32'h0E; #1; check_eq("instr_pc0E", instr, 32'h0023E233);
    pc = 32'h2C; #1; check_eq("instr_pc_wrap", instr, 32'h0023E233);
    @(posedge clk); #1;
    check_eq("done_single_pulse", load_done, 0);
    idle(4);

    // Gapped random loads with correct checksum
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      step(0, 1, $urandom % 2, $urandom, 0, $urandom);
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom % 2) step(0, 0, 0, $urandom, $urandom % 2, $urandom);
        exp_csum = m_sum + w;
        step(0, 0, 1, w, i == n - 1, $urandom);
      end
      idle(3);
    end

    // Overflow: DEPTH words without last
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, $urandom, 0, $urandom);
    check_eq("ovf_err", load_err, 1);
    check_eq("ovf_ready", lif.ld_ready, 0);
    idle(3);
    step(0, 1, 1, $urandom, 0, 0);
    check_eq("ovf_clear_err", load_err, 0);

    // Restart after three words, coincident with a valid word
    for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom, 0, $urandom);
    step(0, 1, 1, 32'hBAD0BAD0, 1, 0);
    check_eq("restart_count", word_count, 0);
    exp_csum = 32'hA5A5A5A5;
    step(0, 0, 1, 32'hA5A5A5A5, 1, 0);
    idle(2);

    // Restart from RUN stalls the core next cycle
    step(0, 1, 0, 0, 0, $urandom);
    check_eq("run_restart_stall", cpu_run, 0);

    // Checksum mismatch by one (only errors when the checksum is built in)
    s = '0;
    foreach (image[i]) s += image[i];
    exp_csum = s + 1;
    for (int i = 0; i < 6; i++) step(0, 0, 1, image[i], i == 5, $urandom);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    exp_csum = s;
    for (int i = 0; i < 6; i++) step(0, 0, 1, image[i], i == 5, $urandom);
    idle(2);

    // Random soak
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = $urandom;
      exp_csum = ($urandom % 2) ? m_sum + w : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, $urandom % 2, w,
           $urandom_range(0, 4) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
